// File: rtl/pipeline_ctrl_unit.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_unit
//
// Central sequencer for the 5-stage MIPS pipeline. It merges hazard-unit
// stall/flush requests, taken-branch flushes and debug run/step/halt commands
// into per-stage register enables and flushes. It also drains the pipeline
// after a HALT instruction and keeps cycle and stall counters for the debug
// unit.
//
// Parameters:
//   CNT_W          width of cycle_cnt / stall_cnt
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   hz_stall       load-use stall request (hazard unit)
//   hz_flush_idex  branch-operand hazard request (hazard unit)
//   branch_taken   branch/jump resolved taken in ID
//   halt_id        HALT opcode decoded in ID
//   wb_halt        HALT instruction has reached WB
//   dbg_run        debug free-run command (1-cycle pulse)
//   dbg_step       debug single-step command (1-cycle pulse)
//   dbg_halt       debug pause command (1-cycle pulse)
//   pc_en          PC load enable
//   if_id_en       IF/ID register enable
//   if_id_flush    IF/ID synchronous clear (NOP insert)
//   id_ex_flush    ID/EX synchronous clear (bubble insert)
//   ex_m_en        EX/MEM register enable
//   m_wb_en        MEM/WB register enable
//   state          current state encoding
//   step_done      1-cycle pulse in the cycle after a STEP cycle
//   halted         high while in HALTED
//   cycle_cnt      saturating count of advancing cycles
//   stall_cnt      saturating count of hazard-stall cycles
// ---------------------------------------------------------------------------
module pipeline_ctrl_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hz_stall,
  input  logic             hz_flush_idex,
  input  logic             branch_taken,
  input  logic             halt_id,
  input  logic             wb_halt,
  input  logic             dbg_run,
  input  logic             dbg_step,
  input  logic             dbg_halt,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_m_en,
  output logic             m_wb_en,
  output logic [2:0]       state,
  output logic             step_done,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RUN    = 3'd1;
  localparam logic [2:0] ST_STEP   = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic             r_step_done;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_hz;
  logic w_exec;      // RUN or STEP: the pipeline is executing instructions
  logic w_adv;       // RUN, STEP or DRAIN: the pipeline is moving
  logic w_drain_req; // HALT seen in ID and not held back by a hazard

  assign w_hz        = hz_stall | hz_flush_idex;
  assign w_exec      = (r_state == ST_RUN) | (r_state == ST_STEP);
  assign w_adv       = w_exec | (r_state == ST_DRAIN);
  // A stalled HALT is still waiting in ID; it only triggers the drain once
  // it can actually move forward.
  assign w_drain_req = w_exec & halt_id & ~w_hz;

  // Next-state selection; HALTED is terminal and only reset leaves it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (dbg_halt) begin
          w_state_nxt = ST_IDLE;
        end else if (dbg_step) begin
          w_state_nxt = ST_STEP;
        end else if (dbg_run) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_drain_req) begin
          w_state_nxt = ST_DRAIN;
        end else if (dbg_halt) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_STEP: begin
        // A step always lasts one cycle, stalled or not.
        if (w_drain_req) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        // Debug commands are deliberately ignored so the drain completes.
        if (wb_halt) begin
          w_state_nxt = ST_HALTED;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_HALTED: begin
        w_state_nxt = ST_HALTED;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Per-stage enables and flushes from current state and same-cycle inputs.
  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_m_en     = 1'b0;
    m_wb_en     = 1'b0;
    case (r_state)
      ST_RUN, ST_STEP: begin
        if (w_hz) begin
          // Hold PC and IF/ID, push a bubble into EX, let the back end drain.
          // The branch flush is suppressed: the branch is re-evaluated once
          // the hazard clears.
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          if_id_flush = 1'b0;
          id_ex_flush = 1'b1;
          ex_m_en     = 1'b1;
          m_wb_en     = 1'b1;
        end else begin
          // HALT in ID freezes the PC so no instruction past it is fetched.
          pc_en       = ~halt_id;
          if_id_en    = 1'b1;
          if_id_flush = branch_taken;
          id_ex_flush = 1'b0;
          ex_m_en     = 1'b1;
          m_wb_en     = 1'b1;
        end
      end
      ST_DRAIN: begin
        // Feed NOPs behind the HALT until it retires.
        pc_en       = 1'b0;
        if_id_en    = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b0;
        ex_m_en     = 1'b1;
        m_wb_en     = 1'b1;
      end
      ST_IDLE, ST_HALTED: begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        ex_m_en     = 1'b0;
        m_wb_en     = 1'b0;
      end
      default: begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        ex_m_en     = 1'b0;
        m_wb_en     = 1'b0;
      end
    endcase
  end

  // State register and the step-completion pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_step_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_step_done <= (r_state == ST_STEP);
    end
  end

  // Saturating cycle and stall counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycle_cnt <= CNT_ZERO;
      r_stall_cnt <= CNT_ZERO;
    end else begin
      if (w_adv && (r_cycle_cnt != CNT_MAX)) begin
        r_cycle_cnt <= r_cycle_cnt + CNT_ONE;
      end else begin
        r_cycle_cnt <= r_cycle_cnt;
      end
      if (w_exec && w_hz && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
    end
  end

  assign state     = r_state;
  assign step_done = r_step_done;
  assign halted    = (r_state == ST_HALTED);
  assign cycle_cnt = r_cycle_cnt;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl_unit
//
// Self-checking bench: directed scenarios followed by random stimulus, every
// output compared against a behavioural model. Two instances share the same
// inputs: one with 32-bit counters, one with 4-bit counters so saturation is
// reachable.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl_unit;

  logic clk = 1'b0;
  logic reset;
  logic hz_stall, hz_flush_idex, branch_taken, halt_id, wb_halt;
  logic dbg_run, dbg_step, dbg_halt;

  logic        a_pc_en, a_if_id_en, a_if_id_flush, a_id_ex_flush, a_ex_m_en, a_m_wb_en;
  logic [2:0]  a_state;
  logic        a_step_done, a_halted;
  logic [31:0] a_cycle_cnt, a_stall_cnt;

  logic        b_pc_en, b_if_id_en, b_if_id_flush, b_id_ex_flush, b_ex_m_en, b_m_wb_en;
  logic [2:0]  b_state;
  logic        b_step_done, b_halted;
  logic [3:0]  b_cycle_cnt, b_stall_cnt;

  int n_total = 0;
  int n_bad   = 0;

  // Model of the sequencer: mode, pending step pulse, unbounded counts.
  int     m_mode;   // 0 idle, 1 run, 2 step, 3 drain, 4 halted
  bit     m_step_done;
  longint m_cycles;
  longint m_stalls;

  // Stimulus vector bit positions.
  localparam int B_STALL = 7, B_HFL = 6, B_BR = 5, B_HID = 4;
  localparam int B_WB = 3, B_RUN = 2, B_STEP = 1, B_DHLT = 0;

  always #5 clk = ~clk;

  pipeline_ctrl_unit #(.CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .hz_stall(hz_stall), .hz_flush_idex(hz_flush_idex),
    .branch_taken(branch_taken), .halt_id(halt_id), .wb_halt(wb_halt),
    .dbg_run(dbg_run), .dbg_step(dbg_step), .dbg_halt(dbg_halt),
    .pc_en(a_pc_en), .if_id_en(a_if_id_en), .if_id_flush(a_if_id_flush),
    .id_ex_flush(a_id_ex_flush), .ex_m_en(a_ex_m_en), .m_wb_en(a_m_wb_en),
    .state(a_state), .step_done(a_step_done), .halted(a_halted),
    .cycle_cnt(a_cycle_cnt), .stall_cnt(a_stall_cnt)
  );

  pipeline_ctrl_unit #(.CNT_W(4)) u_dut_w4 (
    .clk(clk), .reset(reset), .hz_stall(hz_stall), .hz_flush_idex(hz_flush_idex),
    .branch_taken(branch_taken), .halt_id(halt_id), .wb_halt(wb_halt),
    .dbg_run(dbg_run), .dbg_step(dbg_step), .dbg_halt(dbg_halt),
    .pc_en(b_pc_en), .if_id_en(b_if_id_en), .if_id_flush(b_if_id_flush),
    .id_ex_flush(b_id_ex_flush), .ex_m_en(b_ex_m_en), .m_wb_en(b_m_wb_en),
    .state(b_state), .step_done(b_step_done), .halted(b_halted),
    .cycle_cnt(b_cycle_cnt), .stall_cnt(b_stall_cnt)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_m_en, m_wb_en}.
  function automatic logic [5:0] exp_ctl(input int mode, input logic [7:0] v);
    bit hz;
    hz = v[B_STALL] || v[B_HFL];
    if (mode == 3) return 6'b011011;                 // drain: NOPs into IF/ID
    if (mode != 1 && mode != 2) return 6'b000000;   // frozen
    if (hz) return 6'b000111;                        // stall + bubble
    return {!v[B_HID], 1'b1, v[B_BR], 1'b0, 1'b1, 1'b1};
  endfunction

  function automatic longint sat(input longint x, input longint maxv);
    return (x > maxv) ? maxv : x;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_step_done = 0; m_cycles = 0; m_stalls = 0;
  endtask

  task automatic check_all(input logic [7:0] v);
    logic [5:0] e;
    e = exp_ctl(m_mode, v);
    chk("ctl32", {a_pc_en, a_if_id_en, a_if_id_flush, a_id_ex_flush, a_ex_m_en, a_m_wb_en}, e);
    chk("ctl4",  {b_pc_en, b_if_id_en, b_if_id_flush, b_id_ex_flush, b_ex_m_en, b_m_wb_en}, e);
    chk("state", {a_state, b_state}, {m_mode[2:0], m_mode[2:0]});
    chk("step_done", {a_step_done, b_step_done}, {m_step_done, m_step_done});
    chk("halted", {a_halted, b_halted}, {m_mode == 4, m_mode == 4});
    chk("cycle_cnt32", a_cycle_cnt, sat(m_cycles, 64'hFFFF_FFFF));
    chk("stall_cnt32", a_stall_cnt, sat(m_stalls, 64'hFFFF_FFFF));
    chk("cycle_cnt4", b_cycle_cnt, sat(m_cycles, 15));
    chk("stall_cnt4", b_stall_cnt, sat(m_stalls, 15));
  endtask

  // Model step: what one clock edge does given the cycle's inputs.
  task automatic model_edge(input logic [7:0] v);
    bit hz, executing;
    int nxt;
    hz = v[B_STALL] || v[B_HFL];
    executing = (m_mode == 1) || (m_mode == 2);
    nxt = m_mode;
    if (executing && v[B_HID] && !hz)      nxt = 3;
    else if (m_mode == 2)                  nxt = 0;
    else if (m_mode == 1)                  nxt = v[B_DHLT] ? 0 : 1;
    else if (m_mode == 0)                  nxt = v[B_DHLT] ? 0 : v[B_STEP] ? 2 : v[B_RUN] ? 1 : 0;
    else if (m_mode == 3)                  nxt = v[B_WB] ? 4 : 3;
    if (executing || m_mode == 3) m_cycles++;
    if (executing && hz) m_stalls++;
    m_step_done = (m_mode == 2);
    m_mode = nxt;
  endtask

  // One clock: drive at negedge, check just after, advance model at posedge.
  task automatic cyc(input logic [7:0] v);
    @(negedge clk);
    {hz_stall, hz_flush_idex, branch_taken, halt_id, wb_halt, dbg_run, dbg_step, dbg_halt} = v;
    #1;
    check_all(v);
    @(posedge clk);
    model_edge(v);
  endtask

  // Reset asserted mid-cycle; outputs must clear before the next edge.
  task automatic mid_reset();
    @(negedge clk);
    {hz_stall, hz_flush_idex, branch_taken, halt_id, wb_halt, dbg_run, dbg_step, dbg_halt} = 8'h00;
    #2 reset = 1'b1;
    model_reset();
    #1;
    check_all(8'h00);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    reset = 1'b1;
    {hz_stall, hz_flush_idex, branch_taken, halt_id, wb_halt, dbg_run, dbg_step, dbg_halt} = 8'h00;
    model_reset();
    #12 reset = 1'b0;

    // Reset then idle.
    repeat (5) cyc(8'h00);

    // Run with a 2-cycle load-use stall.
    cyc(8'h01 << B_RUN);
    cyc(8'h00);
    cyc(8'h01 << B_STALL);
    cyc(8'h01 << B_STALL);
    cyc(8'h00);

    // Branch flush, then the same branch masked by an operand hazard.
    cyc(8'h01 << B_BR);
    cyc((8'h01 << B_BR) | (8'h01 << B_HFL));
    cyc(8'h01 << B_DHLT);

    // Single step, then a stalled single step.
    cyc(8'h01 << B_STEP);
    cyc(8'h00);
    cyc(8'h00);
    cyc(8'h01 << B_STEP);
    cyc(8'h01 << B_STALL);
    cyc(8'h00);
    // Step that hits HALT goes to drain but still pulses step_done.
    cyc(8'h01 << B_STEP);
    cyc(8'h01 << B_HID);
    cyc(8'h00);
    mid_reset();

    // Halt drain: debug halt ignored, wb_halt ends it, run ignored in HALTED.
    cyc(8'h01 << B_RUN);
    cyc(8'h01 << B_HID);
    cyc(8'h01 << B_DHLT);
    cyc(8'h00);
    cyc(8'h01 << B_WB);
    cyc(8'h01 << B_RUN);
    cyc(8'h00);
    mid_reset();

    // Saturation of the narrow counters, then asynchronous reset.
    cyc(8'h01 << B_RUN);
    repeat (20) cyc(8'h00);
    repeat (18) cyc(8'h01 << B_STALL);
    cyc(8'h00);
    mid_reset();

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      v = 8'h00;
      v[B_STALL] = ($urandom_range(0, 5) == 0);
      v[B_HFL]   = ($urandom_range(0, 7) == 0);
      v[B_BR]    = ($urandom_range(0, 3) == 0);
      v[B_HID]   = ($urandom_range(0, 40) == 0);
      v[B_WB]    = ($urandom_range(0, 4) == 0);
      v[B_RUN]   = ($urandom_range(0, 6) == 0);
      v[B_STEP]  = ($urandom_range(0, 6) == 0);
      v[B_DHLT]  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 150) == 0 || (m_mode == 4 && $urandom_range(0, 9) == 0)) begin
        mid_reset();
      end else begin
        cyc(v);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
